// File: rtl/spi_coax_pkg.sv
// Shared definitions for the RHS2116-style SPI link: frame size, command
// opcodes and responder FSM state encoding.
`timescale 1ns/1ps
package spi_coax_pkg;

    parameter int unsigned FRAME_BITS_DEFAULT = 32;

    // Two MSBs of an RHS2116 command word select the operation.
    typedef enum logic [1:0] {
        OP_CONVERT   = 2'b00,
        OP_CALIBRATE = 2'b01,
        OP_WRITE     = 2'b10,
        OP_READ      = 2'b11
    } rhs_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI line with rise/fall
// detection against one further registered copy.
`timescale 1ns/1ps
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk_link,
    input  logic rst_n,
    input  logic raw,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], raw};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rise = chain[SYNC_STAGES-1] & ~prev;
    assign fall = ~chain[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/rhs2116_spi_responder.sv
// RHS2116-style SPI peripheral emulator: oversampled SPI slave that returns a
// counter or an echo of earlier commands, and captures the master's command.
`timescale 1ns/1ps
module rhs2116_spi_responder
    import spi_coax_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ECHO_MODE   = 0,
    parameter int unsigned PIPE_DEPTH  = 2
) (
    input  logic                  clk_link,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic [FRAME_BITS-1:0] rx_cmd,
    output logic                  rx_cmd_valid,
    output logic                  frame_abort,
    output logic [15:0]           frame_cnt
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] BITS_END = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] BITS_LAST = CNT_W'(FRAME_BITS - 1);

    state_t state, state_next;

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_sync;

    logic start, end_frame, shift_rise, shift_fall;

    logic [31:0]           data_cnt;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] rx_next;
    logic [FRAME_BITS-1:0] tx_load;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] pipe [PIPE_DEPTH];

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_link (clk_link),
        .rst_n    (rst_n),
        .raw      (cs_n),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_link (clk_link),
        .rst_n    (rst_n),
        .raw      (sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // Same depth as the sclk chain, so mosi is sampled aligned to the detected fall.
    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        end_frame  = 1'b0;
        shift_rise = 1'b0;
        shift_fall = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_fall && enable) begin
                    start      = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    end_frame  = 1'b1;
                    state_next = ST_IDLE;
                end else if (!cs_fall) begin
                    shift_rise = sclk_rise;
                    shift_fall = sclk_fall;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rx_next = {rx_shift[FRAME_BITS-2:0], mosi_sync};
    assign tx_load = (ECHO_MODE != 0) ? pipe[PIPE_DEPTH-1]
                                      : FRAME_BITS'(data_cnt + 32'd1);

    always_ff @(posedge clk_link or negedge rst_n) begin
        if (!rst_n) begin
            miso         <= 1'b0;
            rx_cmd       <= '0;
            rx_cmd_valid <= 1'b0;
            frame_abort  <= 1'b0;
            frame_cnt    <= '0;
            data_cnt     <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            rx_cmd_valid <= 1'b0;
            frame_abort  <= 1'b0;
            if (start) begin
                data_cnt <= data_cnt + 32'd1;
                tx_shift <= tx_load;
                bit_cnt  <= '0;
                miso     <= 1'b0;
            end
            if (end_frame) begin
                miso <= 1'b0;
                if (bit_cnt != '0 && bit_cnt < BITS_END) begin
                    frame_abort <= 1'b1;
                end
            end
            if (shift_rise) begin
                if (bit_cnt < BITS_END) begin
                    miso     <= tx_shift[FRAME_BITS-1];
                    tx_shift <= tx_shift << 1;
                end else begin
                    miso <= 1'b0;
                end
            end
            if (shift_fall && bit_cnt < BITS_END) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == BITS_LAST) begin
                    rx_cmd       <= rx_next;
                    rx_cmd_valid <= 1'b1;
                    frame_cnt    <= frame_cnt + 16'd1;
                    for (int unsigned i = PIPE_DEPTH - 1; i > 0; i--) begin
                        pipe[i] <= pipe[i-1];
                    end
                    pipe[0] <= rx_next;
                end
            end
        end
    end

endmodule
